// File: rtl/wb_register_file_if.sv
// Write-back / ID-read / dump bundle for wb_register_file.
// Signals:
//   reg_write_i, reg_RDaddr_i, reg_RDdata_i : write-back from MEM/WB
//   RS1addr_i, RS2addr_i                    : ID-stage source addresses
//   RS1data_o, RS2data_o                    : ID-stage source data (combinational)
//   dump_start_i, dump_ready_i              : dump request / consumer ready
//   dump_valid_o, dump_addr_o, dump_data_o  : dump beat
//   dump_busy_o, dump_done_o                : dump status
// Modports: slave = register file, master = pipeline / bench side.
interface wb_register_file_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              reg_write_i;
    logic [ADDR_W-1:0] reg_RDaddr_i;
    logic [DATA_W-1:0] reg_RDdata_i;
    logic [ADDR_W-1:0] RS1addr_i;
    logic [ADDR_W-1:0] RS2addr_i;
    logic [DATA_W-1:0] RS1data_o;
    logic [DATA_W-1:0] RS2data_o;
    logic              dump_start_i;
    logic              dump_ready_i;
    logic              dump_valid_o;
    logic [ADDR_W-1:0] dump_addr_o;
    logic [DATA_W-1:0] dump_data_o;
    logic              dump_busy_o;
    logic              dump_done_o;

    modport slave (
        input  reg_write_i, reg_RDaddr_i, reg_RDdata_i, RS1addr_i, RS2addr_i,
               dump_start_i, dump_ready_i,
        output RS1data_o, RS2data_o, dump_valid_o, dump_addr_o, dump_data_o,
               dump_busy_o, dump_done_o
    );

    modport master (
        output reg_write_i, reg_RDaddr_i, reg_RDdata_i, RS1addr_i, RS2addr_i,
               dump_start_i, dump_ready_i,
        input  RS1data_o, RS2data_o, dump_valid_o, dump_addr_o, dump_data_o,
               dump_busy_o, dump_done_o
    );
endinterface

// File: rtl/wb_register_file.sv
// Architectural register file fed by the MEM/WB write-back stage.
// Two combinational read ports with write-to-read bypass, x0 hard-wired to zero,
// and a valid/ready dump port that walks every register in index order.
// Ports:
//   clk_i : clock, all state updates on posedge
//   rst_i : asynchronous active-high reset (clears registers and dump FSM)
//   bus   : wb_register_file_if.slave (write-back, ID reads, dump port)
module wb_register_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    wb_register_file_if.slave      bus
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {StIdle, StSend, StDone} dump_state_e;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] snap_q, snap_d;

    // Read value seen this cycle: x0 is zero, a same-cycle write wins over storage.
    function automatic logic [DATA_W-1:0] bypass_rd(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (addr == '0) begin
            return '0;
        end else if (we && (waddr == addr)) begin
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    // Register array
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.reg_write_i && (bus.reg_RDaddr_i != '0)) begin
            regs_q[bus.reg_RDaddr_i] <= bus.reg_RDdata_i;
        end
    end

    // ID-stage read ports
    always_comb begin
        bus.RS1data_o = bypass_rd(bus.RS1addr_i, regs_q[bus.RS1addr_i], bus.reg_write_i,
                                  bus.reg_RDaddr_i, bus.reg_RDdata_i);
        bus.RS2data_o = bypass_rd(bus.RS2addr_i, regs_q[bus.RS2addr_i], bus.reg_write_i,
                                  bus.reg_RDaddr_i, bus.reg_RDdata_i);
    end

    // Dump FSM state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    // Dump FSM next state and outputs
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        snap_d           = snap_q;
        bus.dump_valid_o = 1'b0;
        bus.dump_addr_o  = '0;
        bus.dump_data_o  = '0;
        bus.dump_busy_o  = 1'b0;
        bus.dump_done_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.dump_start_i) begin
                    state_d = StSend;
                    idx_d   = '0;
                    snap_d  = '0;  // x0 always reads zero
                end
            end
            StSend: begin
                bus.dump_valid_o = 1'b1;
                bus.dump_busy_o  = 1'b1;
                bus.dump_addr_o  = idx_q;
                bus.dump_data_o  = snap_q;
                // Without ready the snapshot is held, so a write to the held
                // register does not disturb the beat in flight.
                if (bus.dump_ready_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d  = idx_q + ADDR_W'(1);
                        snap_d = bypass_rd(idx_d, regs_q[idx_d], bus.reg_write_i,
                                           bus.reg_RDaddr_i, bus.reg_RDdata_i);
                    end
                end
            end
            StDone: begin
                bus.dump_done_o = 1'b1;
                state_d         = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end
endmodule

// File: tb/tb_wb_register_file.sv
module tb_wb_register_file;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_REGS = 32;

    logic clk_i;
    logic rst_i;
    int   n_checks;
    int   n_fail;

    wb_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    wb_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int cyc;
        n_checks = 0;
        n_fail   = 0;
        bus.reg_write_i  = 1'b0;
        bus.reg_RDaddr_i = '0;
        bus.reg_RDdata_i = '0;
        bus.RS1addr_i    = '0;
        bus.RS2addr_i    = '0;
        bus.dump_start_i = 1'b0;
        bus.dump_ready_i = 1'b0;
        rst_i = 1'b1;
        #2;

        // 1. Reset state
        check("rst_valid", 64'(bus.dump_valid_o), 64'd0);
        check("rst_busy",  64'(bus.dump_busy_o),  64'd0);
        check("rst_done",  64'(bus.dump_done_o),  64'd0);
        check("rst_addr",  64'(bus.dump_addr_o),  64'd0);
        check("rst_data",  64'(bus.dump_data_o),  64'd0);
        for (int i = 1; i < NUM_REGS; i++) begin
            bus.RS1addr_i = ADDR_W'(i);
            #1;
            check("rst_read", 64'(bus.RS1data_o), 64'd0);
        end
        tick();
        rst_i = 1'b0;
        tick();

        // Write to x0 is dropped
        bus.reg_write_i  = 1'b1;
        bus.reg_RDaddr_i = 5'd0;
        bus.reg_RDdata_i = 32'hDEADBEEF;
        bus.RS1addr_i    = 5'd0;
        #1;
        check("x0_bypass", 64'(bus.RS1data_o), 64'd0);
        tick();
        bus.reg_write_i = 1'b0;
        #1;
        check("x0_after", 64'(bus.RS1data_o), 64'd0);

        // 2. Write / read
        bus.reg_write_i  = 1'b1;
        bus.reg_RDaddr_i = 5'd5;
        bus.reg_RDdata_i = 32'h12345678;
        tick();
        bus.reg_write_i = 1'b0;
        bus.RS1addr_i   = 5'd5;
        bus.RS2addr_i   = 5'd6;
        #1;
        check("wr_x5", 64'(bus.RS1data_o), 64'h12345678);
        check("wr_x6", 64'(bus.RS2data_o), 64'd0);

        // 3. Bypass on both ports
        bus.reg_write_i  = 1'b1;
        bus.reg_RDaddr_i = 5'd7;
        bus.reg_RDdata_i = 32'hA5A5A5A5;
        bus.RS1addr_i    = 5'd7;
        bus.RS2addr_i    = 5'd7;
        #1;
        check("byp_rs1", 64'(bus.RS1data_o), 64'hA5A5A5A5);
        check("byp_rs2", 64'(bus.RS2data_o), 64'hA5A5A5A5);
        bus.RS2addr_i = 5'd5;
        #1;
        check("byp_rs2_other", 64'(bus.RS2data_o), 64'h12345678);
        tick();
        bus.reg_write_i = 1'b0;

        // 4. Full dump, xi = i*4
        for (int i = 1; i < NUM_REGS; i++) begin
            bus.reg_write_i  = 1'b1;
            bus.reg_RDaddr_i = ADDR_W'(i);
            bus.reg_RDdata_i = 32'(i * 4);
            tick();
        end
        bus.reg_write_i  = 1'b0;
        bus.dump_ready_i = 1'b1;
        bus.dump_start_i = 1'b1;
        tick();
        cyc = 1;
        bus.dump_start_i = 1'b0;
        for (int b = 0; b < NUM_REGS; b++) begin
            check("dump_valid", 64'(bus.dump_valid_o), 64'd1);
            check("dump_addr",  64'(bus.dump_addr_o),  64'(b));
            check("dump_data",  64'(bus.dump_data_o),  64'(b * 4));
            check("dump_nodone", 64'(bus.dump_done_o), 64'd0);
            tick();
            cyc++;
        end
        check("dump_done_cyc", 64'(cyc), 64'd33);
        check("dump_done",     64'(bus.dump_done_o),  64'd1);
        check("dump_done_val", 64'(bus.dump_valid_o), 64'd0);
        tick();
        check("dump_done_once", 64'(bus.dump_done_o), 64'd0);
        check("dump_idle_busy", 64'(bus.dump_busy_o), 64'd0);

        // 5. Backpressure with write to the held register
        bus.dump_start_i = 1'b1;
        tick();
        bus.dump_start_i = 1'b0;
        tick();
        tick();
        tick();
        check("bp_addr3", 64'(bus.dump_addr_o), 64'd3);
        bus.dump_ready_i = 1'b0;
        bus.reg_write_i  = 1'b1;
        bus.reg_RDaddr_i = 5'd3;
        bus.reg_RDdata_i = 32'hFFFF0000;
        tick();
        bus.reg_write_i = 1'b0;
        check("bp_hold_addr", 64'(bus.dump_addr_o), 64'd3);
        check("bp_hold_data", 64'(bus.dump_data_o), 64'd12);
        tick();
        check("bp_hold2_data", 64'(bus.dump_data_o), 64'd12);
        bus.RS1addr_i = 5'd3;
        #1;
        check("bp_x3_read", 64'(bus.RS1data_o), 64'hFFFF0000);
        bus.dump_ready_i = 1'b1;
        tick();
        check("bp_resume_addr", 64'(bus.dump_addr_o), 64'd4);
        check("bp_resume_data", 64'(bus.dump_data_o), 64'd16);
        // Snapshot of the next beat sees this cycle's write; start is ignored
        bus.reg_write_i  = 1'b1;
        bus.reg_RDaddr_i = 5'd5;
        bus.reg_RDdata_i = 32'hCAFE0005;
        bus.dump_start_i = 1'b1;
        tick();
        bus.reg_write_i  = 1'b0;
        bus.dump_start_i = 1'b0;
        check("snap_byp_addr", 64'(bus.dump_addr_o), 64'd5);
        check("snap_byp_data", 64'(bus.dump_data_o), 64'hCAFE0005);
        for (int i = 0; i < 5; i++) tick();
        check("beat10_addr", 64'(bus.dump_addr_o), 64'd10);
        check("beat10_data", 64'(bus.dump_data_o), 64'd40);

        // 6. Asynchronous reset mid-dump, between edges
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_valid", 64'(bus.dump_valid_o), 64'd0);
        check("arst_busy",  64'(bus.dump_busy_o),  64'd0);
        check("arst_done",  64'(bus.dump_done_o),  64'd0);
        check("arst_addr",  64'(bus.dump_addr_o),  64'd0);
        check("arst_data",  64'(bus.dump_data_o),  64'd0);
        bus.RS1addr_i = 5'd3;
        bus.RS2addr_i = 5'd31;
        #1;
        check("arst_x3",  64'(bus.RS1data_o), 64'd0);
        check("arst_x31", 64'(bus.RS2data_o), 64'd0);
        tick();
        #2;
        rst_i = 1'b0;
        tick();
        check("post_rst_busy", 64'(bus.dump_busy_o), 64'd0);
        check("post_rst_done", 64'(bus.dump_done_o), 64'd0);
        tick();
        check("post_rst_done2", 64'(bus.dump_done_o), 64'd0);
        bus.dump_start_i = 1'b1;
        tick();
        bus.dump_start_i = 1'b0;
        check("restart_valid", 64'(bus.dump_valid_o), 64'd1);
        check("restart_addr",  64'(bus.dump_addr_o),  64'd0);
        tick();
        check("restart_x1", 64'(bus.dump_data_o), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
